// File: rtl/alu_arb_if.sv
// rtl/alu_arb_if.sv - requester, response and ALU signal bundle for alu_arb
//
// Purpose: groups every handshake/bus signal of alu_arb so the block can be
// connected with a single interface port. Clock and reset stay outside.
//
// Signals (suffix _i / _o is from the point of view of alu_arb):
//   req{0,1}_valid_i / req{0,1}_ready_o   operation request handshake
//   req{0,1}_op_i, req{0,1}_a_i, req{0,1}_b_i   opcode and operands
//   rsp{0,1}_valid_o / rsp{0,1}_ready_i   result response handshake
//   rsp{0,1}_data_o                       result data
//   alu_op_o, alu_a_o, alu_b_o            drive to the combinational ALU
//   alu_result_i                          combinational ALU result
//   busy_o                                high whenever the sequencer is not idle
//
// Modports:
//   slave  - used by alu_arb
//   master - used by the environment (requesters, responders and ALU)
interface alu_arb_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
);
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [OP_W-1:0]   req0_op_i;
  logic [DATA_W-1:0] req0_a_i;
  logic [DATA_W-1:0] req0_b_i;

  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [OP_W-1:0]   req1_op_i;
  logic [DATA_W-1:0] req1_a_i;
  logic [DATA_W-1:0] req1_b_i;

  logic              rsp0_valid_o;
  logic              rsp0_ready_i;
  logic [DATA_W-1:0] rsp0_data_o;

  logic              rsp1_valid_o;
  logic              rsp1_ready_i;
  logic [DATA_W-1:0] rsp1_data_o;

  logic [OP_W-1:0]   alu_op_o;
  logic [DATA_W-1:0] alu_a_o;
  logic [DATA_W-1:0] alu_b_o;
  logic [DATA_W-1:0] alu_result_i;

  logic              busy_o;

  modport slave (
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    output req0_ready_o,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    output req1_ready_o,
    output rsp0_valid_o, rsp0_data_o,
    input  rsp0_ready_i,
    output rsp1_valid_o, rsp1_data_o,
    input  rsp1_ready_i,
    output alu_op_o, alu_a_o, alu_b_o,
    input  alu_result_i,
    output busy_o
  );

  modport master (
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    input  req0_ready_o,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    input  req1_ready_o,
    input  rsp0_valid_o, rsp0_data_o,
    output rsp0_ready_i,
    input  rsp1_valid_o, rsp1_data_o,
    output rsp1_ready_i,
    input  alu_op_o, alu_a_o, alu_b_o,
    output alu_result_i,
    input  busy_o
  );
endinterface

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - two-requester arbiter and sequencer for a shared combinational ALU
//
// Purpose: accepts one operation at a time from requester 0 or 1, latches the
// opcode and operands, presents them to the ALU for one execute cycle,
// registers the result and returns it on the owner's response channel.
// Sequence: IDLE (handshake) -> EXEC (ALU evaluates) -> RESP (hold until taken).
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_n_i  - asynchronous active-low reset
//   bus      - alu_arb_if.slave: request, response, ALU and busy signals
//
// Configuration macro:
//   ALU_ARB_RR_EN - when defined, ties are broken round-robin (the requester
//                   not granted last wins); otherwise requester 0 wins ties.
module alu_arb #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  alu_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q,  last_d;
  logic [OP_W-1:0]   op_q,    op_d;
  logic [DATA_W-1:0] a_q,     a_d;
  logic [DATA_W-1:0] b_q,     b_d;
  logic [DATA_W-1:0] res_q,   res_d;

  logic grant;      // index of the winning requester (meaningful when any valid)
  logic accept;     // a request handshake completes this cycle
  logic rsp_take;   // the owner takes the result this cycle

  // Arbitration
  always_comb begin
    grant = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      grant = ~last_q;
    end else begin
      grant = bus.req1_valid_i;
    end
`else
    grant = bus.req1_valid_i & ~bus.req0_valid_i;
`endif
  end

`ifndef ALU_ARB_RR_EN
  // The last-grant register is still maintained in fixed-priority builds so
  // both variants carry identical state; it simply has no reader here.
  logic last_grant_unused;
  assign last_grant_unused = last_q;
`endif

  // Ready is gated with reset so it reads 0 while reset is held, even though
  // the FSM sits in IDLE and requesters may already be asserting valid.
  assign accept   = (state_q == IDLE) && rst_n_i &&
                    (bus.req0_valid_i || bus.req1_valid_i);
  assign rsp_take = owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = EXEC;
      EXEC:                  state_d = RESP;
      RESP:    if (rsp_take) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Operand, owner, last-grant and result registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Operands are sampled only on the handshake cycle; the result only at the
  // end of EXEC, so it stays stable through the whole RESP phase.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    if (accept) begin
      owner_d = grant;
      last_d  = grant;
      if (grant) begin
        op_d = bus.req1_op_i;
        a_d  = bus.req1_a_i;
        b_d  = bus.req1_b_i;
      end else begin
        op_d = bus.req0_op_i;
        a_d  = bus.req0_a_i;
        b_d  = bus.req0_b_i;
      end
    end
    if (state_q == EXEC) begin
      res_d = bus.alu_result_i;
    end
  end

  // Output logic
  always_comb begin
    bus.req0_ready_o = accept & ~grant;
    bus.req1_ready_o = accept &  grant;
    bus.rsp0_valid_o = (state_q == RESP) & ~owner_q;
    bus.rsp1_valid_o = (state_q == RESP) &  owner_q;
    bus.rsp0_data_o  = res_q;
    bus.rsp1_data_o  = res_q;
    bus.alu_op_o     = op_q;
    bus.alu_a_o      = a_q;
    bus.alu_b_o      = b_q;
    bus.busy_o       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - self-checking bench for alu_arb with a reference model
module tb_alu_arb;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   model_last;
  bit   g_seen [4];
  bit   dummy_w;

  always #5 clk = ~clk;

  alu_arb_if #(.DATA_W(32), .OP_W(6)) bus_if ();

  alu_arb #(.DATA_W(32), .OP_W(6)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_if)
  );

  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      6'b010000: return a + b;
      6'b010001: return a - b;
      6'b010010: return a & b;
      6'b010011: return a | b;
      6'b010100: return a ^ b;
      default:   return a << b[4:0];
    endcase
  endfunction

  always_comb bus_if.alu_result_i = alu_fn(bus_if.alu_op_o, bus_if.alu_a_o, bus_if.alu_b_o);

  function automatic logic [5:0] pick_op();
    return 6'b010000 + 6'($urandom_range(0, 5));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction; entered and left at a falling edge.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [5:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [5:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input int delay, output bit won);
    bit          exp_w;
    logic [5:0]  eop;
    logic [31:0] ea, eb, eres;
    bus_if.req0_valid_i = v0;
    bus_if.req0_op_i    = op0;
    bus_if.req0_a_i     = a0;
    bus_if.req0_b_i     = b0;
    bus_if.req1_valid_i = v1;
    bus_if.req1_op_i    = op1;
    bus_if.req1_a_i     = a1;
    bus_if.req1_b_i     = b1;
    #1;
    // Reference arbitration rule
    if (v0 && v1) exp_w = RR ? ~model_last : 1'b0;
    else          exp_w = v1;
    won = bus_if.req1_ready_o;
    check("req0_ready_hs", bus_if.req0_ready_o, v0 && !exp_w);
    check("req1_ready_hs", bus_if.req1_ready_o, v1 && exp_w);
    eop  = exp_w ? op1 : op0;
    ea   = exp_w ? a1 : a0;
    eb   = exp_w ? b1 : b0;
    eres = alu_fn(eop, ea, eb);
    model_last = exp_w;

    @(posedge clk); @(negedge clk);
    // Operands change after the handshake; the latched copy must not follow.
    bus_if.req0_a_i  = $urandom;
    bus_if.req0_b_i  = $urandom;
    bus_if.req0_op_i = pick_op();
    bus_if.req1_a_i  = $urandom;
    bus_if.req1_b_i  = $urandom;
    bus_if.req1_op_i = pick_op();
    #1;
    check("exec_busy", bus_if.busy_o, 1);
    check("exec_alu_op", bus_if.alu_op_o, eop);
    check("exec_alu_a", bus_if.alu_a_o, ea);
    check("exec_alu_b", bus_if.alu_b_o, eb);
    check("exec_ready", {bus_if.req0_ready_o, bus_if.req1_ready_o}, 0);
    check("exec_rsp_valid", {bus_if.rsp0_valid_o, bus_if.rsp1_valid_o}, 0);

    @(posedge clk); @(negedge clk);
    check("resp_valid", {bus_if.rsp1_valid_o, bus_if.rsp0_valid_o}, exp_w ? 2'b10 : 2'b01);
    check("resp_data0", bus_if.rsp0_data_o, eres);
    check("resp_data1", bus_if.rsp1_data_o, eres);
    check("resp_busy", bus_if.busy_o, 1);
    check("resp_ready", {bus_if.req0_ready_o, bus_if.req1_ready_o}, 0);
    if (exp_w) begin
      bus_if.rsp1_ready_i = (delay == 0);
      bus_if.rsp0_ready_i = 1'($urandom);
    end else begin
      bus_if.rsp0_ready_i = (delay == 0);
      bus_if.rsp1_ready_i = 1'($urandom);
    end
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", {bus_if.rsp1_valid_o, bus_if.rsp0_valid_o}, exp_w ? 2'b10 : 2'b01);
      check("hold_data", exp_w ? bus_if.rsp1_data_o : bus_if.rsp0_data_o, eres);
      check("hold_busy", bus_if.busy_o, 1);
      check("hold_ready", {bus_if.req0_ready_o, bus_if.req1_ready_o}, 0);
      if (i == delay - 1) begin
        if (exp_w) bus_if.rsp1_ready_i = 1'b1;
        else       bus_if.rsp0_ready_i = 1'b1;
      end
    end

    @(posedge clk); @(negedge clk);
    check("done_busy", bus_if.busy_o, 0);
    check("done_rsp_valid", {bus_if.rsp0_valid_o, bus_if.rsp1_valid_o}, 0);
    bus_if.req0_valid_i = 1'b0;
    bus_if.req1_valid_i = 1'b0;
    bus_if.rsp0_ready_i = 1'b0;
    bus_if.rsp1_ready_i = 1'b0;
  endtask

  initial begin
    bus_if.req0_valid_i = 1'b1;
    bus_if.req1_valid_i = 1'b1;
    bus_if.req0_op_i = '0; bus_if.req0_a_i = '0; bus_if.req0_b_i = '0;
    bus_if.req1_op_i = '0; bus_if.req1_a_i = '0; bus_if.req1_b_i = '0;
    bus_if.rsp0_ready_i = 1'b0;
    bus_if.rsp1_ready_i = 1'b0;
    model_last = 1'b1;

    // Reset state, with both requesters already valid
    repeat (2) @(negedge clk);
    check("rst_ready", {bus_if.req0_ready_o, bus_if.req1_ready_o}, 0);
    check("rst_rsp_valid", {bus_if.rsp0_valid_o, bus_if.rsp1_valid_o}, 0);
    check("rst_busy", bus_if.busy_o, 0);
    check("rst_alu", {bus_if.alu_op_o, bus_if.alu_a_o, bus_if.alu_b_o}, 0);
    check("rst_rsp_data", {bus_if.rsp0_data_o, bus_if.rsp1_data_o}, 0);
    bus_if.req0_valid_i = 1'b0;
    bus_if.req1_valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single add on requester 0, single sub on requester 1
    run_op(1, 0, 6'b010000, 32'd5, 32'd7, 6'd0, 32'd0, 32'd0, 0, dummy_w);
    run_op(0, 1, 6'd0, 32'd0, 32'd0, 6'b010001, 32'd3, 32'd5, 0, dummy_w);

    // Four tied rounds
    for (int r = 0; r < 4; r++) begin
      run_op(1, 1, pick_op(), $urandom, $urandom, pick_op(), $urandom, $urandom, 0, g_seen[r]);
    end
    for (int r = 0; r < 4; r++) begin
      check("tie_grant_seq", g_seen[r], RR ? 1'(r % 2) : 1'b0);
    end

    // Response backpressure for 5 cycles
    run_op(1, 1, 6'b010000, $urandom, $urandom, 6'b010100, $urandom, $urandom, 5, dummy_w);

    // Randomized traffic
    for (int k = 0; k < 25; k++) begin
      int pat;
      pat = $urandom_range(1, 3);
      run_op(pat[0], pat[1], pick_op(), $urandom, $urandom, pick_op(), $urandom, $urandom,
             $urandom_range(0, 3), dummy_w);
    end

    // Reset during EXEC
    bus_if.req0_valid_i = 1'b1; bus_if.req0_op_i = 6'b010000;
    bus_if.req0_a_i = 32'd11; bus_if.req0_b_i = 32'd22;
    bus_if.req1_valid_i = 1'b1; bus_if.req1_op_i = 6'b010001;
    bus_if.req1_a_i = 32'd33; bus_if.req1_b_i = 32'd44;
    @(posedge clk); @(negedge clk);
    check("pre_rst_busy", bus_if.busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus_if.busy_o, 0);
    check("midrst_ready", {bus_if.req0_ready_o, bus_if.req1_ready_o}, 0);
    check("midrst_rsp_valid", {bus_if.rsp0_valid_o, bus_if.rsp1_valid_o}, 0);
    check("midrst_alu_a", bus_if.alu_a_o, 0);
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_hold_rsp", {bus_if.rsp0_valid_o, bus_if.rsp1_valid_o}, 0);
    rst_n = 1'b1;
    bus_if.req0_valid_i = 1'b0;
    bus_if.req1_valid_i = 1'b0;
    @(negedge clk);
    run_op(1, 1, pick_op(), $urandom, $urandom, pick_op(), $urandom, $urandom, 1, g_seen[0]);
    check("post_rst_tie", g_seen[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
